// File: rtl/rr_arbitro_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM
// encoding and the cyclic priority scan used to pick a winner.
package rr_arbitro_8_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        OCUPADO = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Cyclic scan start, start+1, ... (mod N_REQ); the first set bit wins.
    // Iterating from the farthest offset down lets the nearest hit overwrite.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req_vec,
                                      input logic [IDX_W-1:0] start);
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = start + IDX_W'(i);
            if (req_vec[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbitro_8_cod_onehot.sv
// One-hot (8 bit) to binary (3 bit) encoder. Any input that is not exactly
// one-hot, zero included, encodes to 0 so downstream selects never see X.
module cod_onehot_8a3
    import rr_arbitro_8_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic is_onehot;

    assign is_onehot = (onehot != '0) && ((onehot & (onehot - ONE)) == '0);

    // Output bit gi is the OR of every input bit whose index has bit gi set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_bit
            logic [N_REQ-1:0] sel;
            for (gj = 0; gj < N_REQ; gj++) begin : g_in
                assign sel[gj] = onehot[gj] & (((gj >> gi) & 1) != 0);
            end
            assign idx[gi] = is_onehot & (|sel);
        end
    endgenerate

endmodule

// File: rtl/rr_arbitro_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant,
// optional hold limit (MAX_HOLD, 0 = unlimited) and back-to-back handover.
module rr_arbitro_8
    import rr_arbitro_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT    = '1;
    localparam logic [N_REQ-1:0]  ONE_HOT0    = N_REQ'(1);

    state_t            state_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [N_REQ-1:0]  grant_reg;

    logic [IDX_W-1:0]  cur_idx;
    logic [N_REQ-1:0]  masked_req;
    logic [IDX_W-1:0]  scan_start;
    logic              is_released;
    pick_t             pick;
    logic [N_REQ-1:0]  pick_onehot;

    cod_onehot_8a3 u_cod (
        .onehot (grant_reg),
        .idx    (cur_idx)
    );

    // Next winner: the current holder is masked out and, while busy, the scan
    // starts just past it, matching where the pointer lands on release.
    always_comb begin
        masked_req  = req & ~grant_reg;
        is_released = ((req & grant_reg) == '0) ||
                      (HOLD_LIMITED && (hold_cnt_reg == HOLD_LAST));
        scan_start  = (state_reg == OCUPADO) ? (cur_idx + IDX_W'(1)) : ptr_reg;
        pick        = rr_pick(masked_req, scan_start);
        pick_onehot = ONE_HOT0 << pick.idx;
    end

    // Arbitration FSM: grant, pointer and hold counter all update here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            grant_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick.found) begin
                        grant_reg    <= pick_onehot;
                        hold_cnt_reg <= '0;
                        state_reg    <= OCUPADO;
                    end
                end
                OCUPADO: begin
                    if (is_released) begin
                        ptr_reg      <= cur_idx + IDX_W'(1);
                        hold_cnt_reg <= '0;
                        if (pick.found) begin
                            grant_reg <= pick_onehot;
                        end else begin
                            grant_reg <= '0;
                            state_reg <= IDLE;
                        end
                    end else if (hold_cnt_reg != HOLD_SAT) begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_idx   = cur_idx;
    assign grant_valid = |grant_reg;

endmodule

// File: tb/tb_rr_arbitro_8.sv
// Bench for rr_arbitro_8: three instances (MAX_HOLD 16, 4, 0) share one
// stimulus stream; a queue-free behavioural model per instance is compared
// every cycle, and directed scenarios pin the model with literal values.
module tb_rr_arbitro_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt   [3];
    logic [2:0] gidx  [3];
    logic       gval  [3];

    int tests = 0;
    int fails = 0;

    int mh     [3] = '{16, 4, 0};
    int m_g    [3];
    int m_ptr  [3];
    int m_held [3];
    bit model_live = 0;

    rr_arbitro_8 #(.MAX_HOLD(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(gnt[0]), .grant_idx(gidx[0]), .grant_valid(gval[0]));
    rr_arbitro_8 #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(gnt[1]), .grant_idx(gidx[1]), .grant_valid(gval[1]));
    rr_arbitro_8 #(.MAX_HOLD(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(gnt[2]), .grant_idx(gidx[2]), .grant_valid(gval[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // First requester at or after 'start' (cyclically) that is set and not excluded.
    function automatic int find(input logic [7:0] r, input int start, input int excl);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (start + i) % 8;
            if (r[k] && k != excl) return k;
        end
        return -1;
    endfunction

    // Model: m_g is the granted index (-1 none), m_held counts visible cycles.
    task automatic model_step();
        int w;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_g[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
            end else if (m_g[d] < 0) begin
                w = find(req, m_ptr[d], -1);
                if (w >= 0) begin m_g[d] = w; m_held[d] = 1; end
            end else if (!req[m_g[d]] || (mh[d] != 0 && m_held[d] >= mh[d])) begin
                m_ptr[d]  = (m_g[d] + 1) % 8;
                w         = find(req, m_ptr[d], m_g[d]);
                m_g[d]    = w;
                m_held[d] = (w >= 0) ? 1 : 0;
            end else begin
                m_held[d]++;
            end
        end
        if (!rst_n) model_live = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every instance against the model.
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            for (int d = 0; d < 3; d++) begin
                logic [7:0] eg;
                logic [7:0] ei;
                eg = (m_g[d] < 0) ? 8'h00 : (8'h01 << m_g[d]);
                ei = (m_g[d] < 0) ? 8'h00 : 8'(m_g[d]);
                chk($sformatf("model_grant[%0d]", d), gnt[d], eg);
                chk($sformatf("model_idx[%0d]", d), {5'b0, gidx[d]}, ei);
                chk($sformatf("model_valid[%0d]", d), {7'b0, gval[d]}, {7'b0, (m_g[d] >= 0)});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] e;
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);

        // Single request, release, pointer moves to 5
        do_reset();
        chk("reset_grant", gnt[0], 8'h00);
        chk("reset_valid", {7'b0, gval[0]}, 8'h00);
        req = 8'h10;
        @(negedge clk);
        chk("single_grant", gnt[0], 8'h10);
        chk("single_idx", {5'b0, gidx[0]}, 8'd4);
        chk("single_valid", {7'b0, gval[0]}, 8'h01);
        req = 8'h00;
        @(negedge clk);
        chk("drop_grant", gnt[0], 8'h00);
        req = 8'h11;
        @(negedge clk);
        chk("ptr5_grant", gnt[0], 8'h01);
        $display("[TB] directed single request done");

        // All request, each drops after its grant: 0..7 back to back
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = 8'h01 << k;
            chk($sformatf("sweep_grant%0d", k), gnt[0], e);
            chk($sformatf("sweep_idx%0d", k), {5'b0, gidx[0]}, 8'(k));
            req[k] = 1'b0;
        end
        $display("[TB] directed all-request sweep done");

        // Wrap from 7 to 0
        do_reset();
        req = 8'h80;
        @(negedge clk);
        chk("wrap_g7", gnt[0], 8'h80);
        req = 8'h81;
        @(negedge clk);
        chk("wrap_hold7", gnt[0], 8'h80);
        req = 8'h01;
        @(negedge clk);
        chk("wrap_g0", gnt[0], 8'h01);
        chk("wrap_idx0", {5'b0, gidx[0]}, 8'h00);
        $display("[TB] directed wrap-around done");

        // Timeout alternation (MAX_HOLD=4) and unlimited hold (MAX_HOLD=0)
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            e = ((c % 8) < 4) ? 8'h01 : 8'h02;
            chk($sformatf("timeout_c%0d", c), gnt[1], e);
            chk($sformatf("nolimit_c%0d", c), gnt[2], 8'h01);
        end
        $display("[TB] directed timeout / unlimited hold done");

        // Reset in the middle of a grant
        do_reset();
        req = 8'h08;
        repeat (3) @(negedge clk);
        chk("mid_grant", gnt[0], 8'h08);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_grant", gnt[0], 8'h00);
        chk("mid_rst_idx", {5'b0, gidx[0]}, 8'h00);
        chk("mid_rst_valid", {7'b0, gval[0]}, 8'h00);
        rst_n = 1'b1;
        req   = 8'h88;
        @(negedge clk);
        chk("post_rst_grant", gnt[0], 8'h08);
        $display("[TB] directed reset mid-grant done");

        // Randomized traffic with sticky requests and occasional resets
        for (int blk = 0; blk < 4; blk++) begin
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                rst_n = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 3) == 0)
                    req = 8'($urandom);
                else if ($urandom_range(0, 3) == 0)
                    req = req & ~gnt[$urandom_range(0, 2)];
            end
            $display("[TB] random block %0d done", blk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
